// File: rtl/instr_control_4bit_pkg.sv
// instr_control_4bit_pkg
//   Shared definitions for the 4-bit datapath instruction controller:
//   opcode constants, ALU function encodings, FSM state encoding and
//   instruction field bit positions.
package instr_control_4bit_pkg;

    // Instruction field positions: [7:6] opcode, [5:4] D, [3:2] A, [1:0] B
    localparam int unsigned OpMsb    = 7;
    localparam int unsigned OpLsb    = 6;
    localparam int unsigned DAddrMsb = 5;
    localparam int unsigned DAddrLsb = 4;
    localparam int unsigned ASelMsb  = 3;
    localparam int unsigned ASelLsb  = 2;
    localparam int unsigned BSelMsb  = 1;
    localparam int unsigned BSelLsb  = 0;

    // Execute-cycle counter holds EXEC_CYCLES-1, at most 7
    localparam int unsigned CntWidth = 3;

    typedef enum logic [1:0] {
        OpMov = 2'b00,
        OpAdd = 2'b01,
        OpSub = 2'b10,
        OpNop = 2'b11
    } opcode_e;

    typedef enum logic [1:0] {
        FuncPassA  = 2'b00,
        FuncAdd    = 2'b01,
        FuncSub    = 2'b10,
        FuncUnused = 2'b11
    } func_e;

    typedef enum logic [1:0] {
        StIdle    = 2'b00,
        StExecute = 2'b01,
        StWrite   = 2'b10
    } state_e;

endpackage

// File: rtl/opcode_decode_4bit.sv
// opcode_decode_4bit
//   Combinational opcode decoder: maps a 2-bit opcode to the ALU function
//   select and a flag saying whether the instruction writes the register file.
// Ports:
//   opcode_i       [1:0]  instruction opcode
//   func_select_o  [1:0]  ALU operation select
//   write_en_o            1 for MOV/ADD/SUB, 0 for NOP
module opcode_decode_4bit
    import instr_control_4bit_pkg::*;
(
    input  logic [1:0] opcode_i,
    output logic [1:0] func_select_o,
    output logic       write_en_o
);

    always_comb begin
        func_select_o = FuncPassA;
        write_en_o    = 1'b0;
        unique case (opcode_i)
            OpMov: begin
                func_select_o = FuncPassA;
                write_en_o    = 1'b1;
            end
            OpAdd: begin
                func_select_o = FuncAdd;
                write_en_o    = 1'b1;
            end
            OpSub: begin
                func_select_o = FuncSub;
                write_en_o    = 1'b1;
            end
            OpNop: begin
                func_select_o = FuncPassA;
                write_en_o    = 1'b0;
            end
            default: begin
                func_select_o = FuncPassA;
                write_en_o    = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/instr_control_4bit.sv
// instr_control_4bit
//   Instruction sequencer for a 4-register datapath. Accepts one instruction
//   per valid/ready handshake, holds it for EXEC_CYCLES cycles while the ALU
//   settles, then pulses load_enable for one cycle to write the result back.
//   NOP is accepted but leaves the controller idle and all outputs unchanged.
// Parameters:
//   EXEC_CYCLES  number of EXECUTE cycles, 1..8
// Ports:
//   clk, rst              clock, synchronous active-high reset
//   instr_valid, instr    upstream instruction offer ([7:6] op, [5:4] D, [3:2] A, [1:0] B)
//   instr_ready           high only when idle and not in reset
//   A_select, B_select    register-file read selects (registered)
//   D_address             register-file write address (registered)
//   load_enable           register-file write strobe (one cycle, in WRITE)
//   func_select           ALU operation (registered)
//   busy                  inverse of instr_ready
// Optional feature (macro STATUS_FLAGS_EN):
//   alu_carry, alu_zero   ALU status inputs
//   flag_c, flag_z        status flags captured at the end of WRITE for ADD/SUB
module instr_control_4bit
    import instr_control_4bit_pkg::*;
#(
    parameter int unsigned EXEC_CYCLES = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       instr_valid,
    input  logic [7:0] instr,
    output logic       instr_ready,
    output logic [1:0] A_select,
    output logic [1:0] B_select,
    output logic [1:0] D_address,
    output logic       load_enable,
    output logic [1:0] func_select,
    output logic       busy
`ifdef STATUS_FLAGS_EN
    ,
    input  logic       alu_carry,
    input  logic       alu_zero,
    output logic       flag_c,
    output logic       flag_z
`endif
);

    localparam logic [CntWidth-1:0] CntLoad = CntWidth'(EXEC_CYCLES - 1);

    state_e              state_q;
    logic [CntWidth-1:0] cnt_q;
    logic [7:0]          ir_q;
    logic [7:0]          ir_d;
    logic                transfer;
    logic [1:0]          dec_func;
    logic                dec_write_en;

    assign instr_ready = (state_q == StIdle) && !rst;
    assign busy        = ~instr_ready;
    assign transfer    = instr_valid && instr_ready;

    // IR next value; outputs are decoded from it so they are valid in the
    // very first EXECUTE cycle.
    always_comb begin
        ir_d = ir_q;
        if (transfer) begin
            ir_d = instr;
        end
    end

    opcode_decode_4bit u_decode (
        .opcode_i      (ir_d[OpMsb:OpLsb]),
        .func_select_o (dec_func),
        .write_en_o    (dec_write_en)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= StIdle;
            cnt_q       <= '0;
            ir_q        <= '0;
            A_select    <= '0;
            B_select    <= '0;
            D_address   <= '0;
            func_select <= FuncPassA;
            load_enable <= 1'b0;
        end else begin
            ir_q <= ir_d;
            unique case (state_q)
                StIdle: begin
                    // NOP (dec_write_en low) stays idle and keeps the old selects
                    if (transfer && dec_write_en) begin
                        state_q     <= StExecute;
                        cnt_q       <= CntLoad;
                        A_select    <= ir_d[ASelMsb:ASelLsb];
                        B_select    <= ir_d[BSelMsb:BSelLsb];
                        D_address   <= ir_d[DAddrMsb:DAddrLsb];
                        func_select <= dec_func;
                    end
                end
                StExecute: begin
                    if (cnt_q == '0) begin
                        state_q     <= StWrite;
                        load_enable <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q - CntWidth'(1);
                    end
                end
                StWrite: begin
                    state_q     <= StIdle;
                    load_enable <= 1'b0;
                end
                default: begin
                    state_q     <= StIdle;
                    load_enable <= 1'b0;
                end
            endcase
        end
    end

`ifdef STATUS_FLAGS_EN
    // IR cannot change outside IDLE, so ir_q still holds the in-flight opcode.
    always_ff @(posedge clk) begin
        if (rst) begin
            flag_c <= 1'b0;
            flag_z <= 1'b0;
        end else if (state_q == StWrite &&
                     (ir_q[OpMsb:OpLsb] == OpAdd || ir_q[OpMsb:OpLsb] == OpSub)) begin
            flag_c <= alu_carry;
            flag_z <= alu_zero;
        end
    end
`endif

endmodule
